traffic_light_timer: RTL

Down-counting interval timer that serves the traffic-light controller FSM: it accepts a `load` pulse with a duration, counts that duration down in ticks, and raises `done` when the interval expires. It is the responder side of the FSM's `load`/`load_value`/`done` timer interface. It adds a tick prescaler, pause/hold, a visible remaining-count output and zero-load error reporting.

---
 rtl/traffic_light_timer.sv | 69 ++++++
 1 files changed

// File: rtl/traffic_light_timer.sv
// traffic_light_timer: down-counting interval timer with pause, zero-load error and optional tick prescaler.
// Define TRAFFIC_TIMER_PRESCALE_EN to tick every PRESCALE clocks; otherwise every running cycle is a tick.
module traffic_light_timer #(
  parameter int WIDTH_TIMER = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load,
  input  logic [WIDTH_TIMER-1:0] load_value,
  input  logic                   pause,
  output logic                   done,
  output logic [WIDTH_TIMER-1:0] count,
  output logic                   busy,
  output logic                   load_err
);
  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
  state_t state, state_n;
  logic [WIDTH_TIMER-1:0] count_n;
  logic done_n, err_n, tick;
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("PRESCALE must be at least 2");
  end
`ifdef TRAFFIC_TIMER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pre, pre_n;
  assign tick = pre == PW'(PRESCALE - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pre <= '0;
    else pre <= pre_n;
  always_comb begin
    pre_n = pre;
    if (load) pre_n = '0;
    else if (state == RUN && !pause) pre_n = tick ? '0 : pre + PW'(1);
  end
`else
  assign tick = 1'b1;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state    <= IDLE;
      count    <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      done     <= done_n;
      load_err <= err_n;
    end
  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = done;
    err_n   = 1'b0;
    if (load) begin
      state_n = load_value != '0 ? RUN : EXPIRED;
      count_n = load_value;
      done_n  = load_value == '0;
      err_n   = load_value == '0;
    end else if (state == RUN && !pause && tick && count != '0) begin
      count_n = count - WIDTH_TIMER'(1);
      // the last tick of the interval lands in EXPIRED with done set
      done_n  = count == WIDTH_TIMER'(1);
      state_n = count == WIDTH_TIMER'(1) ? EXPIRED : RUN;
    end
  end
  assign busy = state == RUN;
endmodule
